// File: rtl/gate_descriptor_pkg.sv
// gate_descriptor_pkg: shared types and descriptor field positions for the gate descriptor fetch block.
// Revision: 1.0
`default_nettype none

package gate_descriptor_pkg;

  typedef enum logic [3:0] {
    GATE_CALL_286 = 4'h4,
    GATE_TASK     = 4'h5,
    GATE_INT_286  = 4'h6,
    GATE_TRAP_286 = 4'h7,
    GATE_CALL_386 = 4'hC,
    GATE_INT_386  = 4'hE,
    GATE_TRAP_386 = 4'hF
  } gate_type_e;

  typedef enum logic [2:0] {
    FAULT_NONE        = 3'd0,
    FAULT_LIMIT       = 3'd1,
    FAULT_TYPE        = 3'd2,
    FAULT_PRIV        = 3'd3,
    FAULT_NOT_PRESENT = 3'd4
  } fault_code_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ_LO = 3'd1,
    READ_HI = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam int SEL_MSB  = 63;
  localparam int SEL_LSB  = 48;
  localparam int OFF_MSB  = 47;
  localparam int OFF_LSB  = 16;
  localparam int P_BIT    = 15;
  localparam int DPL_MSB  = 14;
  localparam int DPL_LSB  = 13;
  localparam int TYPE_MSB = 11;
  localparam int TYPE_LSB = 8;
  localparam int WC_MSB   = 4;
  localparam int WC_LSB   = 0;

  function automatic logic is_valid_gate_type(input logic [3:0] t);
    case (t)
      4'h4, 4'h5, 4'h6, 4'h7, 4'hC, 4'hE, 4'hF: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_descriptor_check.sv
// gate_descriptor_check: combinational fault classification and target-field normalization of a gate descriptor.
// Revision: 1.0
`default_nettype none

module gate_descriptor_check
  import gate_descriptor_pkg::*;
(
  input  logic [63:0] desc,
  input  logic [1:0]  cpl,
  input  logic        check_dpl,
  input  logic        limit_fault,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [3:0]  gate_type,
  output logic [15:0] target_selector,
  output logic [31:0] target_offset,
  output logic [4:0]  word_count,
  output logic        interrupt_disable
);

  logic [3:0]  dtype;
  logic [1:0]  dpl;
  logic        present;
  logic [31:0] raw_offset;
  fault_code_e code;
  logic        unused_bits;

  assign dtype       = desc[TYPE_MSB:TYPE_LSB];
  assign dpl         = desc[DPL_MSB:DPL_LSB];
  assign present     = desc[P_BIT];
  assign raw_offset  = desc[OFF_MSB:OFF_LSB];
  assign unused_bits = ^{desc[12], desc[7:5]};

  always_comb begin
    code = FAULT_NONE;
    if (limit_fault)
      code = FAULT_LIMIT;
    else if (!is_valid_gate_type(dtype))
      code = FAULT_TYPE;
    else if (check_dpl && (cpl > dpl))
      code = FAULT_PRIV;
    else if (!present)
      code = FAULT_NOT_PRESENT;
  end

  always_comb begin
    fault             = (code != FAULT_NONE);
    fault_code        = code;
    gate_type         = limit_fault ? 4'h0 : dtype;
    target_selector   = 16'h0;
    target_offset     = 32'h0;
    word_count        = 5'h0;
    interrupt_disable = 1'b0;
    if (code == FAULT_NONE) begin
      target_selector = desc[SEL_MSB:SEL_LSB];
      // 286 gates carry only a 16-bit offset; task gates carry none.
      case (dtype)
        GATE_CALL_286: begin
          target_offset = {16'h0, raw_offset[15:0]};
          word_count    = desc[WC_MSB:WC_LSB];
        end
        GATE_TASK: target_offset = 32'h0;
        GATE_INT_286: begin
          target_offset     = {16'h0, raw_offset[15:0]};
          interrupt_disable = 1'b1;
        end
        GATE_TRAP_286: target_offset = {16'h0, raw_offset[15:0]};
        GATE_CALL_386: begin
          target_offset = raw_offset;
          word_count    = desc[WC_MSB:WC_LSB];
        end
        GATE_INT_386: begin
          target_offset     = raw_offset;
          interrupt_disable = 1'b1;
        end
        default: target_offset = raw_offset;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/gate_descriptor_fetch_control.sv
// gate_descriptor_fetch_control: fetches a 64-bit gate descriptor over a 32-bit read port and reports target or fault.
// Revision: 1.0
`default_nettype none

module gate_descriptor_fetch_control
  import gate_descriptor_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [15:0]           i_selector,
  input  logic [ADDR_WIDTH-1:0] i_table_base,
  input  logic [15:0]           i_table_limit,
  input  logic [1:0]            i_cpl,
  input  logic                  i_check_dpl,
  input  logic                  i_flush,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ack,
  input  logic [31:0]           i_mem_data,
  output logic                  o_done,
  output logic                  o_fault,
  output logic [2:0]            o_fault_code,
  output logic [3:0]            o_gate_type,
  output logic [15:0]           o_target_selector,
  output logic [31:0]           o_target_offset,
  output logic [4:0]            o_word_count,
  output logic                  o_interrupt_disable
);

  localparam logic [ADDR_WIDTH-1:0] HI_OFFSET = ADDR_WIDTH'(4);

  state_e                state, state_next;
  logic [12:0]           sel_index;
  logic [ADDR_WIDTH-1:0] table_base;
  logic [1:0]            cpl;
  logic                  check_dpl;
  logic                  limit_fault;
  logic [63:0]           desc;
  logic                  accept;
  logic                  limit_exceeded;
  logic [ADDR_WIDTH-1:0] desc_addr;
  logic                  unused_sel_bits;

  logic        chk_fault;
  logic [2:0]  chk_fault_code;
  logic [3:0]  chk_gate_type;
  logic [15:0] chk_target_selector;
  logic [31:0] chk_target_offset;
  logic [4:0]  chk_word_count;
  logic        chk_interrupt_disable;

  assign unused_sel_bits = ^i_selector[2:0];
  assign accept          = (state == IDLE) && i_req_valid && !i_flush;
  // Last byte of the 8-byte entry must lie within the inclusive limit.
  assign limit_exceeded  = {i_selector[15:3], 3'b111} > i_table_limit;
  assign desc_addr       = table_base + {{(ADDR_WIDTH-16){1'b0}}, sel_index, 3'b000};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    o_req_ready = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_addr  = '0;
    o_done      = 1'b0;
    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (accept)
          state_next = limit_exceeded ? CHECK : READ_LO;
      end
      READ_LO: begin
        o_mem_req  = 1'b1;
        o_mem_addr = desc_addr;
        if (i_mem_ack)
          state_next = READ_HI;
      end
      READ_HI: begin
        o_mem_req  = 1'b1;
        o_mem_addr = desc_addr + HI_OFFSET;
        if (i_mem_ack)
          state_next = CHECK;
      end
      CHECK: state_next = DONE;
      DONE: begin
        o_done     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (i_flush)
      state_next = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sel_index   <= '0;
      table_base  <= '0;
      cpl         <= '0;
      check_dpl   <= 1'b0;
      limit_fault <= 1'b0;
      desc        <= '0;
    end else begin
      if (accept) begin
        sel_index   <= i_selector[15:3];
        table_base  <= i_table_base;
        cpl         <= i_cpl;
        check_dpl   <= i_check_dpl;
        limit_fault <= limit_exceeded;
        desc        <= '0;
      end
      if (!i_flush && i_mem_ack) begin
        if (state == READ_LO)
          desc[31:0] <= i_mem_data;
        else if (state == READ_HI)
          desc[63:32] <= i_mem_data;
      end
    end
  end

  gate_descriptor_check u_check (
    .desc              (desc),
    .cpl               (cpl),
    .check_dpl         (check_dpl),
    .limit_fault       (limit_fault),
    .fault             (chk_fault),
    .fault_code        (chk_fault_code),
    .gate_type         (chk_gate_type),
    .target_selector   (chk_target_selector),
    .target_offset     (chk_target_offset),
    .word_count        (chk_word_count),
    .interrupt_disable (chk_interrupt_disable)
  );

  // Results only move on CHECK->DONE so a flushed fetch leaves them intact.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_fault             <= 1'b0;
      o_fault_code        <= '0;
      o_gate_type         <= '0;
      o_target_selector   <= '0;
      o_target_offset     <= '0;
      o_word_count        <= '0;
      o_interrupt_disable <= 1'b0;
    end else if (state == CHECK && !i_flush) begin
      o_fault             <= chk_fault;
      o_fault_code        <= chk_fault_code;
      o_gate_type         <= chk_gate_type;
      o_target_selector   <= chk_target_selector;
      o_target_offset     <= chk_target_offset;
      o_word_count        <= chk_word_count;
      o_interrupt_disable <= chk_interrupt_disable;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_descriptor_fetch_control.sv
// tb_gate_descriptor_fetch_control: directed self-checking bench for gate_descriptor_fetch_control.
// Revision: 1.0
`default_nettype none

module tb_gate_descriptor_fetch_control;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] selector = 16'h0;
  logic [31:0] table_base = 32'h0;
  logic [15:0] table_limit = 16'h0;
  logic [1:0]  cpl = 2'd0;
  logic        check_dpl = 1'b0;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = 32'h0;
  logic        done;
  logic        fault;
  logic [2:0]  fault_code;
  logic [3:0]  gate_type;
  logic [15:0] target_selector;
  logic [31:0] target_offset;
  logic [4:0]  word_count;
  logic        interrupt_disable;

  int checks = 0;
  int errors = 0;
  int done_cyc;
  int mem_cycles;
  int done_seen;

  always #5 clk = ~clk;

  gate_descriptor_fetch_control #(.ADDR_WIDTH(32)) dut (
    .i_clk               (clk),
    .i_reset_n           (reset_n),
    .i_req_valid         (req_valid),
    .o_req_ready         (req_ready),
    .i_selector          (selector),
    .i_table_base        (table_base),
    .i_table_limit       (table_limit),
    .i_cpl               (cpl),
    .i_check_dpl         (check_dpl),
    .i_flush             (flush),
    .o_mem_req           (mem_req),
    .o_mem_addr          (mem_addr),
    .i_mem_ack           (mem_ack),
    .i_mem_data          (mem_data),
    .o_done              (done),
    .o_fault             (fault),
    .o_fault_code        (fault_code),
    .o_gate_type         (gate_type),
    .o_target_selector   (target_selector),
    .o_target_offset     (target_offset),
    .o_word_count        (word_count),
    .o_interrupt_disable (interrupt_disable)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and plays a memory that acks after `waits` idle cycles.
  task automatic run_fetch(input logic [15:0] sel, input logic [31:0] base, input logic [15:0] lim,
                           input logic [1:0] c, input logic chk, input logic [31:0] lo,
                           input logic [31:0] hi, input int waits,
                           output int dcyc, output int mcyc);
    int rd;
    int wcnt;
    logic [31:0] exp_addr;
    rd = 0;
    wcnt = 0;
    dcyc = -1;
    mcyc = 0;
    check("ready_before_req", {63'h0, req_ready}, 64'h1);
    req_valid = 1'b1;
    selector = sel;
    table_base = base;
    table_limit = lim;
    cpl = c;
    check_dpl = chk;
    step();
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      mem_ack = 1'b0;
      if (done) begin
        dcyc = cyc;
        break;
      end
      if (mem_req) begin
        mcyc++;
        exp_addr = base + {16'h0, sel[15:3], 3'b000} + 32'(rd * 4);
        check("mem_addr", {32'h0, mem_addr}, {32'h0, exp_addr});
        if (wcnt == waits) begin
          mem_ack = 1'b1;
          mem_data = (rd == 0) ? lo : hi;
          rd++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      step();
    end
    mem_ack = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic f, input logic [2:0] code,
                              input logic [3:0] t, input logic [15:0] s, input logic [31:0] o,
                              input logic [4:0] wc);
    check({tag, ".fault"},    {63'h0, fault},           {63'h0, f});
    check({tag, ".code"},     {61'h0, fault_code},      {61'h0, code});
    check({tag, ".type"},     {60'h0, gate_type},       {60'h0, t});
    check({tag, ".selector"}, {48'h0, target_selector}, {48'h0, s});
    check({tag, ".offset"},   {32'h0, target_offset},   {32'h0, o});
    check({tag, ".wc"},       {59'h0, word_count},      {59'h0, wc});
  endtask

  initial begin
    step();
    step();
    check("rst.ready",    {63'h0, req_ready},         64'h1);
    check("rst.mem_req",  {63'h0, mem_req},           64'h0);
    check("rst.mem_addr", {32'h0, mem_addr},          64'h0);
    check("rst.done",     {63'h0, done},              64'h0);
    check("rst.intdis",   {63'h0, interrupt_disable}, 64'h0);
    check_result("rst", 1'b0, 3'd0, 4'h0, 16'h0, 32'h0, 5'd0);
    reset_n = 1'b1;
    step();

    // 386 call gate, zero-wait memory
    run_fetch(16'h0018, 32'h0001_0000, 16'h00FF, 2'd0, 1'b0, 32'h5678_EC03, 32'h0010_1234, 0,
              done_cyc, mem_cycles);
    check("call386.done_cyc", 64'(done_cyc), 64'd4);
    check("call386.mem_cycles", 64'(mem_cycles), 64'd2);
    check_result("call386", 1'b0, 3'd0, 4'hC, 16'h0010, 32'h1234_5678, 5'd3);
    check("call386.intdis", {63'h0, interrupt_disable}, 64'h0);
    step();
    check("call386.ready_after", {63'h0, req_ready}, 64'h1);
    check("call386.done_one_cycle", {63'h0, done}, 64'h0);

    // limit fault: entry end 0x1F exceeds limit 0x17
    run_fetch(16'h0018, 32'h0001_0000, 16'h0017, 2'd0, 1'b0, 32'h5678_EC03, 32'h0010_1234, 0,
              done_cyc, mem_cycles);
    check("limit.done_cyc", 64'(done_cyc), 64'd2);
    check("limit.mem_cycles", 64'(mem_cycles), 64'd0);
    check_result("limit", 1'b1, 3'd1, 4'h0, 16'h0, 32'h0, 5'd0);
    step();

    // limit boundary: entry end 0x1F equals limit 0x1F, 386 trap gate
    run_fetch(16'h001B, 32'h0001_0000, 16'h001F, 2'd0, 1'b0, 32'h0000_8F00, 32'h0000_0000, 0,
              done_cyc, mem_cycles);
    check("limit_edge.done_cyc", 64'(done_cyc), 64'd4);
    check_result("limit_edge", 1'b0, 3'd0, 4'hF, 16'h0, 32'h0, 5'd0);
    step();

    // privilege beats not-present
    run_fetch(16'h0018, 32'h0001_0000, 16'h00FF, 2'd3, 1'b1, 32'h0000_0E00, 32'h0000_0000, 0,
              done_cyc, mem_cycles);
    check("priv.done_cyc", 64'(done_cyc), 64'd4);
    check_result("priv", 1'b1, 3'd3, 4'hE, 16'h0, 32'h0, 5'd0);
    step();

    // invalid type 9, present
    run_fetch(16'h0020, 32'h0001_0000, 16'h00FF, 2'd0, 1'b0, 32'h0000_8900, 32'h0005_0000, 0,
              done_cyc, mem_cycles);
    check_result("type", 1'b1, 3'd2, 4'h9, 16'h0, 32'h0, 5'd0);
    step();

    // not present, DPL 3 so privilege passes
    run_fetch(16'h0018, 32'h0001_0000, 16'h00FF, 2'd0, 1'b1, 32'h5678_6E00, 32'h0010_1234, 0,
              done_cyc, mem_cycles);
    check_result("notp", 1'b1, 3'd4, 4'hE, 16'h0, 32'h0, 5'd0);
    step();

    // task gate: offset and word count suppressed
    run_fetch(16'h0030, 32'h0002_0000, 16'h00FF, 2'd3, 1'b1, 32'h5678_E51F, 32'h0028_1234, 0,
              done_cyc, mem_cycles);
    check_result("task", 1'b0, 3'd0, 4'h5, 16'h0028, 32'h0, 5'd0);
    step();

    // 286 call gate with base wrap: reads at 0x0 and 0x4
    run_fetch(16'h0008, 32'hFFFF_FFF8, 16'h00FF, 2'd0, 1'b0, 32'h5678_8405, 32'h0030_1234, 1,
              done_cyc, mem_cycles);
    check("wrap.done_cyc", 64'(done_cyc), 64'd6);
    check_result("wrap", 1'b0, 3'd0, 4'h4, 16'h0030, 32'h0000_5678, 5'd5);
    step();

    // 286 interrupt gate, 3 wait states per read
    run_fetch(16'h0040, 32'h0001_0000, 16'h00FF, 2'd0, 1'b0, 32'h5678_8600, 32'h0008_1234, 3,
              done_cyc, mem_cycles);
    check("int286.done_cyc", 64'(done_cyc), 64'd10);
    check("int286.mem_cycles", 64'(mem_cycles), 64'd8);
    check_result("int286", 1'b0, 3'd0, 4'h6, 16'h0008, 32'h0000_5678, 5'd0);
    check("int286.intdis", {63'h0, interrupt_disable}, 64'h1);
    step();

    // flush during READ_HI with ack in the same cycle
    req_valid = 1'b1;
    selector = 16'h0018;
    table_base = 32'h0001_0000;
    table_limit = 16'h00FF;
    cpl = 2'd0;
    check_dpl = 1'b0;
    step();
    req_valid = 1'b0;
    check("flush.lo_req", {63'h0, mem_req}, 64'h1);
    mem_ack = 1'b1;
    mem_data = 32'hAAAA_EC03;
    step();
    check("flush.hi_addr", {32'h0, mem_addr}, 64'h0001_001C);
    mem_data = 32'h0077_1111;
    flush = 1'b1;
    step();
    flush = 1'b0;
    mem_ack = 1'b0;
    check("flush.mem_req", {63'h0, mem_req}, 64'h0);
    check("flush.ready", {63'h0, req_ready}, 64'h1);
    check("flush.done", {63'h0, done}, 64'h0);
    check_result("flush.kept", 1'b0, 3'd0, 4'h6, 16'h0008, 32'h0000_5678, 5'd0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("late_ack.ready", {63'h0, req_ready}, 64'h1);
    check("late_ack.mem_req", {63'h0, mem_req}, 64'h0);
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) done_seen++;
      step();
    end
    check("flush.no_done", 64'(done_seen), 64'd0);

    // flush together with a request in IDLE: not accepted
    req_valid = 1'b1;
    flush = 1'b1;
    step();
    req_valid = 1'b0;
    flush = 1'b0;
    check("flush_req.ready", {63'h0, req_ready}, 64'h1);
    check("flush_req.mem_req", {63'h0, mem_req}, 64'h0);
    step();
    check("flush_req.still_idle", {63'h0, mem_req}, 64'h0);

    // asynchronous reset during READ_HI with ack pending
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    mem_ack = 1'b1;
    mem_data = 32'h5678_EC03;
    step();
    mem_data = 32'h0010_1234;
    check("rst_mid.hi_req", {63'h0, mem_req}, 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid.mem_req", {63'h0, mem_req}, 64'h0);
    check("rst_mid.ready", {63'h0, req_ready}, 64'h1);
    check_result("rst_mid", 1'b0, 3'd0, 4'h0, 16'h0, 32'h0, 5'd0);
    step();
    reset_n = 1'b1;
    mem_ack = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || mem_req) done_seen++;
      step();
    end
    check("rst_mid.no_done", 64'(done_seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
